mem_arbiter_s: RTL and testbench

Single-port memory arbiter and sequencer shared by the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. It grants one requester at a time and holds exactly one outstanding transaction toward a variable-latency memory. It returns read data and a one-cycle ready to the owner, and drives per-stage stall signals into the pipeline control. Data accesses take priority, and a starvation limit guarantees forward progress for fetches.

---
 rtl/mem_arbiter_s_if.sv | 36 +++
 rtl/mem_arbiter_s.sv | 118 +++++++++++
 tb/tb_mem_arbiter_s.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_s_if.sv
// Bus bundle between the pipeline (IF and MEM stages), the arbiter and the memory.
interface mem_arbiter_s_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        flush;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        stall_if;
   logic        stall_mem;
   logic        m_en;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_valid;

   // Arbiter view
   modport slave (
      input  if_req, if_addr, flush, d_req, d_we, d_addr, d_wdata, m_rdata, m_valid,
      output if_rdata, if_ready, d_rdata, d_ready, stall_if, stall_mem,
             m_en, m_we, m_addr, m_wdata
   );

   // Pipeline + memory view
   modport master (
      output if_req, if_addr, flush, d_req, d_we, d_addr, d_wdata, m_rdata, m_valid,
      input  if_rdata, if_ready, d_rdata, d_ready, stall_if, stall_mem,
             m_en, m_we, m_addr, m_wdata
   );
endinterface

// File: rtl/mem_arbiter_s.sv
// Single-port memory arbiter: IF vs MEM stage, one outstanding transaction,
// data priority with a starvation limit that guarantees fetch progress.
module mem_arbiter_s #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   mem_arbiter_s_if.slave  bus
);

   localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

   state_e      state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic        drop_q, drop_d;
   logic        m_en_q;
   logic        m_we_q;
   logic [31:0] m_addr_q;
   logic [31:0] m_wdata_q;
   logic [31:0] if_rdata_q;
   logic [31:0] d_rdata_q;

   logic        grant_if, grant_d;
   logic        complete;
   logic        if_done, d_done;
   logic [31:0] d_load_data;

   // m_valid during the issue cycle (or in idle) is not a completion
   assign complete    = (state_q != StIdle) && !m_en_q && bus.m_valid;
   assign d_load_data = m_we_q ? 32'h0 : bus.m_rdata;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= StIdle;
      else         state_q <= state_d;
   end

   // Grant decision and next state
   always_comb begin
      grant_if = 1'b0;
      grant_d  = 1'b0;
      state_d  = state_q;
      unique case (state_q)
         StIdle: begin
            if (!bus.flush && bus.if_req && (starve_q == Limit)) grant_if = 1'b1;
            else if (bus.d_req)                                   grant_d  = 1'b1;
            else if (!bus.flush && bus.if_req)                    grant_if = 1'b1;
            if (grant_if)     state_d = StBusyI;
            else if (grant_d) state_d = StBusyD;
         end
         StBusyI, StBusyD: begin
            if (complete) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs: completion pulses, read data bypass, stalls, memory bus
   always_comb begin
      // A flush in the completion cycle also discards the fetch
      if_done       = (state_q == StBusyI) && complete && !drop_q && !bus.flush;
      d_done        = (state_q == StBusyD) && complete;
      bus.if_ready  = if_done;
      bus.d_ready   = d_done;
      bus.if_rdata  = if_done ? bus.m_rdata : if_rdata_q;
      bus.d_rdata   = d_done ? d_load_data : d_rdata_q;
      bus.stall_if  = bus.if_req & ~if_done;
      bus.stall_mem = bus.d_req & ~d_done;
      bus.m_en      = m_en_q;
      bus.m_we      = m_we_q;
      bus.m_addr    = m_addr_q;
      bus.m_wdata   = m_wdata_q;
   end

   // Starvation counter and drop flag next state
   always_comb begin
      starve_d = starve_q;
      if (grant_if) begin
         starve_d = 4'd0;
      end else if (grant_d) begin
         if (!bus.if_req)             starve_d = 4'd0;
         else if (starve_q != Limit)  starve_d = starve_q + 4'd1;
      end
      drop_d = 1'b0;
      if (state_q == StBusyI && !complete) drop_d = drop_q | bus.flush;
   end

   // Transaction latch, returned data and bookkeeping registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_en_q     <= 1'b0;
         m_we_q     <= 1'b0;
         m_addr_q   <= 32'h0;
         m_wdata_q  <= 32'h0;
         if_rdata_q <= 32'h0;
         d_rdata_q  <= 32'h0;
         starve_q   <= 4'd0;
         drop_q     <= 1'b0;
      end else begin
         m_en_q   <= grant_if | grant_d;
         starve_q <= starve_d;
         drop_q   <= drop_d;
         if (grant_if) begin
            m_addr_q <= bus.if_addr;
            m_we_q   <= 1'b0;
         end else if (grant_d) begin
            m_addr_q  <= bus.d_addr;
            m_we_q    <= bus.d_we;
            m_wdata_q <= bus.d_wdata;
         end
         if (if_done) if_rdata_q <= bus.m_rdata;
         if (d_done)  d_rdata_q  <= d_load_data;
      end
   end

endmodule

// File: tb/tb_mem_arbiter_s.sv
// Bench for mem_arbiter_s: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_mem_arbiter_s;

   localparam int unsigned LIMIT = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_s_if bus_if ();

   mem_arbiter_s #(.STARVE_LIMIT(LIMIT)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus_if)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: who owns the memory, whether this is the issue cycle,
   // the transaction parameters and the last data returned to each port.
   int          mdl_owner;  // 0 none, 1 fetch, 2 data
   bit          mdl_fresh;
   int          mdl_starve;
   bit          mdl_drop;
   logic [31:0] mdl_addr, mdl_wdata, mdl_if_rdata, mdl_d_rdata;
   bit          mdl_we;
   bit          c_done, c_if_rdy, c_d_rdy;

   // Memory responder
   bit mem_pend, spur_en, force_valid;
   int mem_cnt, mem_lat;

   // Observation logs
   logic [31:0] issue_addr[$];
   logic [31:0] issue_wdata[$];
   logic        issue_we[$];
   int          issue_cyc[$];
   int          n_if_ready, n_d_ready, n_stall_if, dready_cyc;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      if (a == 32'h10) return 32'h13;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mdl_owner = 0; mdl_fresh = 0; mdl_starve = 0; mdl_drop = 0;
      mdl_addr = '0; mdl_wdata = '0; mdl_we = 0;
      mdl_if_rdata = '0; mdl_d_rdata = '0;
      mem_pend = 0;
   endtask

   task automatic clr_logs();
      issue_addr.delete(); issue_wdata.delete(); issue_we.delete(); issue_cyc.delete();
      n_if_ready = 0; n_d_ready = 0; n_stall_if = 0; dready_cyc = -1;
   endtask

   task automatic drive_mem();
      logic v;
      v = 1'b0;
      if (mem_pend) begin
         if (mem_cnt == 0) begin
            v = 1'b1;
            mem_pend = 0;
         end else begin
            mem_cnt--;
         end
      end
      if (spur_en && (mdl_owner == 0 || mdl_fresh) && $urandom_range(7) == 0) v = 1'b1;
      bus_if.m_valid = v | force_valid;
      bus_if.m_rdata = mem_data(mdl_addr);
   endtask

   task automatic check_outputs();
      logic [31:0] exp_if, exp_d;
      c_done   = (mdl_owner != 0) && !mdl_fresh && bus_if.m_valid;
      c_if_rdy = c_done && mdl_owner == 1 && !mdl_drop && !bus_if.flush;
      c_d_rdy  = c_done && mdl_owner == 2;
      exp_if   = c_if_rdy ? bus_if.m_rdata : mdl_if_rdata;
      exp_d    = c_d_rdy ? (mdl_we ? 32'h0 : bus_if.m_rdata) : mdl_d_rdata;
      chk("m_en",      32'(bus_if.m_en),      32'(mdl_fresh));
      chk("m_we",      32'(bus_if.m_we),      32'(mdl_we));
      chk("m_addr",    bus_if.m_addr,         mdl_addr);
      chk("m_wdata",   bus_if.m_wdata,        mdl_wdata);
      chk("if_ready",  32'(bus_if.if_ready),  32'(c_if_rdy));
      chk("d_ready",   32'(bus_if.d_ready),   32'(c_d_rdy));
      chk("if_rdata",  bus_if.if_rdata,       exp_if);
      chk("d_rdata",   bus_if.d_rdata,        exp_d);
      chk("stall_if",  32'(bus_if.stall_if),  32'(bus_if.if_req && !c_if_rdy));
      chk("stall_mem", 32'(bus_if.stall_mem), 32'(bus_if.d_req && !c_d_rdy));
      if (bus_if.m_en) begin
         issue_addr.push_back(bus_if.m_addr);
         issue_wdata.push_back(bus_if.m_wdata);
         issue_we.push_back(bus_if.m_we);
         issue_cyc.push_back(cyc);
      end
      if (bus_if.if_ready) n_if_ready++;
      if (bus_if.d_ready) begin
         n_d_ready++;
         dready_cyc = cyc;
      end
      if (bus_if.stall_if) n_stall_if++;
   endtask

   // Apply the arbitration rules to the inputs seen at this clock edge
   task automatic advance();
      bit gi, gd;
      if (mdl_owner == 0) begin
         gi = !bus_if.flush && bus_if.if_req && mdl_starve == int'(LIMIT);
         gd = 0;
         if (!gi) begin
            gd = bus_if.d_req;
            if (!gd) gi = !bus_if.flush && bus_if.if_req;
         end
         if (gi) begin
            mdl_owner = 1; mdl_addr = bus_if.if_addr; mdl_we = 0; mdl_starve = 0;
         end else if (gd) begin
            mdl_owner = 2; mdl_addr = bus_if.d_addr; mdl_we = bus_if.d_we;
            mdl_wdata = bus_if.d_wdata;
            if (!bus_if.if_req) mdl_starve = 0;
            else if (mdl_starve < int'(LIMIT)) mdl_starve++;
         end
         mdl_fresh = gi || gd;
         if (gi || gd) begin
            mem_pend = 1;
            mem_cnt  = mem_lat;
         end
      end else begin
         if (mdl_owner == 1 && bus_if.flush) mdl_drop = 1;
         if (c_if_rdy) mdl_if_rdata = bus_if.m_rdata;
         if (c_d_rdy) mdl_d_rdata = mdl_we ? 32'h0 : bus_if.m_rdata;
         if (c_done) begin
            mdl_owner = 0;
            mdl_drop  = 0;
         end
         mdl_fresh = 0;
      end
   endtask

   // One cycle: inputs were set just after the previous edge
   task automatic tick();
      drive_mem();
      #2;
      check_outputs();
      cyc++;
      @(posedge clk);
      advance();
      #1;
   endtask

   task automatic tick_until(input int which, input int budget);
      bit hit;
      hit = 0;
      for (int i = 0; i < budget && !hit; i++) begin
         tick();
         hit = (which == 1) ? c_if_rdy : c_d_rdy;
      end
      chk("ready_within_budget", 32'(hit), 32'd1);
   endtask

   // Finish outstanding requests, dropping each one as it completes
   task automatic drain(input int budget);
      for (int i = 0; i < budget && (bus_if.if_req || bus_if.d_req); i++) begin
         tick();
         if (c_if_rdy) bus_if.if_req = 0;
         if (c_d_rdy) bus_if.d_req = 0;
      end
      chk("drain_done", 32'(bus_if.if_req | bus_if.d_req), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] prev_if;
      bus_if.if_req = 0; bus_if.if_addr = '0; bus_if.flush = 0;
      bus_if.d_req = 0; bus_if.d_we = 0; bus_if.d_addr = '0; bus_if.d_wdata = '0;
      bus_if.m_valid = 0; bus_if.m_rdata = '0;
      spur_en = 0; force_valid = 0; mem_lat = 2;
      model_reset();
      clr_logs();

      // Reset values; stalls follow requests even in reset
      #1;
      bus_if.if_req = 1; bus_if.d_req = 1;
      #1;
      check_outputs();
      bus_if.if_req = 0; bus_if.d_req = 0;
      #10 rst_n = 1;
      @(posedge clk);
      #1;

      // Single fetch, memory answers two cycles after m_en
      clr_logs();
      bus_if.if_req = 1; bus_if.if_addr = 32'h10;
      tick_until(1, 10);
      bus_if.if_req = 0;
      tick();
      chk("fetch_ready_count", n_if_ready, 1);
      chk("fetch_stall_cycles", n_stall_if, 3);
      chk("fetch_issues", issue_addr.size(), 1);
      chk("fetch_addr", issue_addr[0], 32'h10);
      chk("fetch_rdata_held", bus_if.if_rdata, 32'h13);

      // Simultaneous requests: data first, fetch issues two cycles after d_ready
      clr_logs();
      bus_if.if_req = 1; bus_if.if_addr = 32'h40;
      bus_if.d_req = 1; bus_if.d_we = 0; bus_if.d_addr = 32'h100;
      tick_until(2, 10);
      bus_if.d_req = 0;
      tick_until(1, 10);
      bus_if.if_req = 0;
      tick();
      chk("prio_first", issue_addr[0], 32'h100);
      chk("prio_second", issue_addr[1], 32'h40);
      chk("prio_gap", issue_cyc[1] - dready_cyc, 2);
      chk("prio_stall_if", n_stall_if, 7);

      // Starvation: both held, minimum latency
      clr_logs();
      mem_lat = 1;
      bus_if.if_req = 1; bus_if.if_addr = 32'h80;
      bus_if.d_req = 1; bus_if.d_we = 0; bus_if.d_addr = 32'h300;
      for (int i = 0; i < 40 && issue_addr.size() < 6; i++) tick();
      drain(20);
      for (int i = 0; i < 4; i++) chk("starve_data_grant", issue_addr[i], 32'h300);
      chk("starve_if_grant", issue_addr[4], 32'h80);
      chk("starve_data_resume", issue_addr[5], 32'h300);

      // Store
      clr_logs();
      mem_lat = 2;
      bus_if.d_req = 1; bus_if.d_we = 1; bus_if.d_addr = 32'h200; bus_if.d_wdata = 32'hDEAD_BEEF;
      tick_until(2, 10);
      bus_if.d_req = 0; bus_if.d_we = 0;
      tick();
      chk("store_we", 32'(issue_we[0]), 32'd1);
      chk("store_wdata", issue_wdata[0], 32'hDEAD_BEEF);
      chk("store_rdata", bus_if.d_rdata, 32'h0);

      // Flush in the issue cycle of a fetch; pipeline then retargets
      clr_logs();
      prev_if = mem_data(32'h80);
      bus_if.if_req = 1; bus_if.if_addr = 32'h44;
      tick();
      bus_if.flush = 1; bus_if.if_addr = 32'h48;
      tick();
      bus_if.flush = 0;
      tick();
      tick();
      chk("flush_no_ready", n_if_ready, 0);
      chk("flush_rdata_kept", bus_if.if_rdata, prev_if);
      tick_until(1, 10);
      bus_if.if_req = 0;
      tick();
      chk("flush_reissue_count", issue_addr.size(), 2);
      chk("flush_reissue_addr", issue_addr[1], 32'h48);
      chk("flush_one_ready", n_if_ready, 1);

      // Flush in idle blocks a fetch grant for that cycle
      clr_logs();
      bus_if.if_req = 1; bus_if.if_addr = 32'h50; bus_if.flush = 1;
      tick();
      bus_if.flush = 0;
      tick();
      chk("idle_flush_no_issue", issue_addr.size(), 0);
      tick_until(1, 10);
      bus_if.if_req = 0;
      tick();

      // Reset while a load is outstanding, then a late m_valid
      clr_logs();
      mem_lat = 3;
      bus_if.d_req = 1; bus_if.d_we = 0; bus_if.d_addr = 32'h180;
      tick();
      tick();
      rst_n = 0;
      #1;
      model_reset();
      check_outputs();
      bus_if.d_req = 0;
      @(posedge clk);
      #3 rst_n = 1;
      @(posedge clk);
      #1;
      force_valid = 1;
      tick();
      force_valid = 0;
      tick();
      chk("reset_no_d_ready", n_d_ready, 0);

      // Random traffic
      spur_en = 1;
      for (int i = 0; i < 600; i++) begin
         mem_lat = int'($urandom_range(1, 4));
         bus_if.flush = ($urandom_range(9) == 0);
         if (!bus_if.if_req && $urandom_range(2) == 0) begin
            bus_if.if_req = 1;
            bus_if.if_addr = {$urandom_range(255), 2'b00};
         end
         if (!bus_if.d_req && $urandom_range(2) == 0) begin
            bus_if.d_req = 1;
            bus_if.d_we = 1'($urandom_range(1));
            bus_if.d_addr = {$urandom_range(1023), 2'b00};
            bus_if.d_wdata = $urandom;
         end
         tick();
         if (c_if_rdy) bus_if.if_req = 1'($urandom_range(1));
         if (c_if_rdy) bus_if.if_addr = {$urandom_range(255), 2'b00};
         if (c_d_rdy) begin
            bus_if.d_req = 1'($urandom_range(1));
            bus_if.d_we = 1'($urandom_range(1));
            bus_if.d_addr = {$urandom_range(1023), 2'b00};
            bus_if.d_wdata = $urandom;
         end
      end
      bus_if.flush = 0;
      spur_en = 0;
      drain(60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
